// File: rtl/data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// data_bus_arbiter
//
// Merges N_CH cache-side petition/ready channels onto one memory-side
// petition/ready channel. Only one transaction is in flight at a time. The
// winning channel's op, address and store line are captured in registers, so
// the memory side sees stable values while the transaction runs.
//
// Parameters:
//   N_CH    number of consumer channels (>= 2)
//   ADDR_W  address width
//   LINE_W  data line width
//   RR_EN   1 = round-robin arbitration, 0 = fixed priority (channel 0 wins)
//
// Ports (channel i uses slice [i*W +: W] of every packed channel vector):
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   c_addr        channel addresses                      (N_CH*ADDR_W)
//   c_ldp, c_srp  channel load / store petitions         (N_CH)
//   c_srData      channel store lines                    (N_CH*LINE_W)
//   c_ldr, c_srr  channel load / store ready pulses      (N_CH)
//   c_ldData      load line, valid while c_ldr[i] is high
//   m_addr        address to memory
//   m_ldp, m_srp  load / store petitions to memory
//   m_srData      store line to memory
//   m_ldr, m_srr  memory load / store ready
//   m_ldData      memory load line
// ---------------------------------------------------------------------------
module data_bus_arbiter #(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 32,
   parameter int RR_EN  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH*ADDR_W-1:0]   c_addr,
   input  logic [N_CH-1:0]          c_ldp,
   input  logic [N_CH-1:0]          c_srp,
   input  logic [N_CH*LINE_W-1:0]   c_srData,
   output logic [N_CH-1:0]          c_ldr,
   output logic [N_CH-1:0]          c_srr,
   output logic [LINE_W-1:0]        c_ldData,
   output logic [ADDR_W-1:0]        m_addr,
   output logic                     m_ldp,
   output logic                     m_srp,
   output logic [LINE_W-1:0]        m_srData,
   input  logic                     m_ldr,
   input  logic                     m_srr,
   input  logic [LINE_W-1:0]        m_ldData
);

   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t                 state;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       gnt_idx;
   logic                   op_store;

   logic [N_CH-1:0]        pending;
   logic                   win_found;
   logic [IDX_W-1:0]       win_idx;
   logic [IDX_W-1:0]       next_ptr;
   logic [N_CH-1:0]        gnt_onehot;
   logic                   op_done;
   logic [ADDR_W-1:0]      addr_arr   [N_CH];
   logic [LINE_W-1:0]      srdata_arr [N_CH];

   // A channel is pending if it has either petition up. A channel raising
   // both at once gets its store served first; the load is picked up again
   // as an ordinary request on a later pass through IDLE.
   assign pending = c_ldp | c_srp;

   // Unpack the packed channel vectors into arrays so the winner's fields
   // can be selected by index.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         addr_arr[i]   = c_addr[i*ADDR_W +: ADDR_W];
         srdata_arr[i] = c_srData[i*LINE_W +: LINE_W];
      end
   end

   // Winner selection. Round-robin scans from rr_ptr upward and wraps around
   // modulo N_CH; fixed priority scans from channel 0. The first pending
   // candidate found in the scan wins.
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand      = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = 0; off < N_CH; off++) begin
         if (RR_EN != 0) begin
            cand = IDX_W'((int'(rr_ptr) + off) % N_CH);
         end else begin
            cand = IDX_W'(off);
         end
         if (!win_found && pending[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Helpers for the sequential block: the pointer value after the current
   // grant, a one-hot mask of the granted channel, and whether memory has
   // returned the ready that matches the latched op. A ready of the other
   // kind does not count.
   assign next_ptr   = (gnt_idx == IDX_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
   assign gnt_onehot = {{(N_CH-1){1'b0}}, 1'b1} << gnt_idx;
   assign op_done    = op_store ? m_srr : m_ldr;

   // Main controller. Every output is a register, so the memory petitions
   // rise one cycle after the grant and the channel ready appears one cycle
   // after the memory ready. Reset clears the petitions asynchronously, which
   // abandons any request in flight without ever answering it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         gnt_idx  <= '0;
         op_store <= 1'b0;
         m_addr   <= '0;
         m_ldp    <= 1'b0;
         m_srp    <= 1'b0;
         m_srData <= '0;
         c_ldr    <= '0;
         c_srr    <= '0;
         c_ldData <= '0;
      end else begin
         case (state)
            IDLE: begin
               c_ldr <= '0;
               c_srr <= '0;
               if (win_found) begin
                  gnt_idx  <= win_idx;
                  op_store <= c_srp[win_idx];
                  m_addr   <= addr_arr[win_idx];
                  m_srData <= srdata_arr[win_idx];
                  m_srp    <= c_srp[win_idx];
                  m_ldp    <= ~c_srp[win_idx];
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (op_done) begin
                  if (!op_store) begin
                     c_ldData <= m_ldData;
                  end
                  m_ldp <= 1'b0;
                  m_srp <= 1'b0;
                  c_ldr <= op_store ? '0 : gnt_onehot;
                  c_srr <= op_store ? gnt_onehot : '0;
                  state <= RESP;
               end
            end
            RESP: begin
               c_ldr <= '0;
               c_srr <= '0;
               if (RR_EN != 0) begin
                  rr_ptr <= next_ptr;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_bus_arbiter
//
// Directed bench for data_bus_arbiter. It builds two 4-channel instances that
// share the channel inputs: one round-robin and one fixed priority. Inputs are
// driven on the falling edge and outputs are observed on that same falling
// edge, which places them half a cycle after the rising edge that updated
// them. A small memory responder can answer each instance's petitions in the
// cycle they rise. It returns the address XOR a key as the line.
// ---------------------------------------------------------------------------
module tb_data_bus_arbiter;

   localparam int NCH = 4;
   localparam int AW  = 32;
   localparam int LW  = 32;
   localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

   logic              clock;
   logic              reset;
   logic [NCH*AW-1:0] cAddr;
   logic [NCH-1:0]    cLdp;
   logic [NCH-1:0]    cSrp;
   logic [NCH*LW-1:0] cSrData;
   logic              mLdr;
   logic              mSrr;
   logic [LW-1:0]     mLdData;
   logic              autoMem;

   logic [NCH-1:0]    rrCLdr, rrCSrr, fpCLdr, fpCSrr;
   logic [LW-1:0]     rrCLdData, fpCLdData;
   logic [AW-1:0]     rrMAddr, fpMAddr;
   logic              rrMLdp, rrMSrp, fpMLdp, fpMSrp;
   logic [LW-1:0]     rrMSrData, fpMSrData;
   logic              rrMLdr, rrMSrr, fpMLdr, fpMSrr;
   logic [LW-1:0]     rrMLdData, fpMLdData;

   logic [31:0]       chAddr   [NCH];
   logic [31:0]       chSrData [NCH];
   int                grantOrder [6];

   int checkCount;
   int passCount;

   // The memory side is either driven by hand or answered automatically:
   // the matching ready rises in the same cycle as the petition.
   assign rrMLdr    = autoMem ? rrMLdp : mLdr;
   assign rrMSrr    = autoMem ? rrMSrp : mSrr;
   assign rrMLdData = autoMem ? (rrMAddr ^ DATA_KEY) : mLdData;
   assign fpMLdr    = autoMem ? fpMLdp : mLdr;
   assign fpMSrr    = autoMem ? fpMSrp : mSrr;
   assign fpMLdData = autoMem ? (fpMAddr ^ DATA_KEY) : mLdData;

   data_bus_arbiter #(.N_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .RR_EN(1)) u_rr (
      .clk(clock), .rst(reset),
      .c_addr(cAddr), .c_ldp(cLdp), .c_srp(cSrp), .c_srData(cSrData),
      .c_ldr(rrCLdr), .c_srr(rrCSrr), .c_ldData(rrCLdData),
      .m_addr(rrMAddr), .m_ldp(rrMLdp), .m_srp(rrMSrp), .m_srData(rrMSrData),
      .m_ldr(rrMLdr), .m_srr(rrMSrr), .m_ldData(rrMLdData)
   );

   data_bus_arbiter #(.N_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .RR_EN(0)) u_fp (
      .clk(clock), .rst(reset),
      .c_addr(cAddr), .c_ldp(cLdp), .c_srp(cSrp), .c_srData(cSrData),
      .c_ldr(fpCLdr), .c_srr(fpCSrr), .c_ldData(fpCLdData),
      .m_addr(fpMAddr), .m_ldp(fpMLdp), .m_srp(fpMSrp), .m_srData(fpMSrData),
      .m_ldr(fpMLdr), .m_srr(fpMSrr), .m_ldData(fpMLdData)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count one comparison and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // Advance to the next falling edge and drive one cycle of inputs.
   task automatic applyStimulus(input logic [3:0] ldp, input logic [3:0] srp,
                                input logic ldr, input logic srr,
                                input logic [31:0] data);
      @(negedge clock);
      cLdp    = ldp;
      cSrp    = srp;
      mLdr    = ldr;
      mSrr    = srr;
      mLdData = data;
   endtask

   // Directed sequence: reset values, single load, store+load on one channel
   // with stray readies, reset mid-transaction, and then fairness versus
   // fixed priority under continuous load traffic.
   initial begin
      int rrCount;
      int fpCount;
      int budget;

      checkCount = 0;
      passCount  = 0;
      chAddr     = '{32'h200, 32'h100, 32'h300, 32'h400};
      chSrData   = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
      grantOrder = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < NCH; i++) begin
         cAddr[i*AW +: AW]   = chAddr[i];
         cSrData[i*LW +: LW] = chSrData[i];
      end
      reset   = 1'b1;
      autoMem = 1'b0;
      cLdp    = '0;
      cSrp    = '0;
      mLdr    = 1'b0;
      mSrr    = 1'b0;
      mLdData = '0;

      repeat (2) @(negedge clock);
      checkOutput("rst_m_ldp", 32'(rrMLdp), 32'd0);
      checkOutput("rst_m_srp", 32'(rrMSrp), 32'd0);
      checkOutput("rst_m_addr", rrMAddr, 32'd0);
      checkOutput("rst_m_srData", rrMSrData, 32'd0);
      checkOutput("rst_c_ldr", 32'(rrCLdr), 32'd0);
      checkOutput("rst_c_srr", 32'(rrCSrr), 32'd0);
      checkOutput("rst_c_ldData", rrCLdData, 32'd0);
      reset = 1'b0;

      // Single load on channel 1, memory answers in cycle 3.
      applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p1_cyc0_m_ldp", 32'(rrMLdp), 32'd0);
      for (int cyc = 1; cyc <= 3; cyc++) begin
         applyStimulus(4'b0010, 4'b0000, (cyc == 3), 1'b0, 32'hA5);
         checkOutput("p1_m_ldp", 32'(rrMLdp), 32'd1);
         checkOutput("p1_m_addr", rrMAddr, 32'h100);
         checkOutput("p1_c_ldr_quiet", 32'(rrCLdr), 32'd0);
      end
      applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p1_c_ldr", 32'(rrCLdr), 32'b0010);
      checkOutput("p1_c_ldData", rrCLdData, 32'hA5);
      checkOutput("p1_m_ldp_drop", 32'(rrMLdp), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p1_c_ldr_after", 32'(rrCLdr), 32'd0);
      checkOutput("p1_c_srr_after", 32'(rrCSrr), 32'd0);

      // Channel 0 raises load and store together: store first, then load.
      applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0);
      applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b1, 32'h0);
      checkOutput("p2_m_srp", 32'(rrMSrp), 32'd1);
      checkOutput("p2_m_ldp_low", 32'(rrMLdp), 32'd0);
      checkOutput("p2_m_addr", rrMAddr, 32'h200);
      checkOutput("p2_m_srData", rrMSrData, 32'hDEAD_0000);
      applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0);
      checkOutput("p2_c_srr", 32'(rrCSrr), 32'b0001);
      checkOutput("p2_c_ldr_none", 32'(rrCLdr), 32'd0);
      checkOutput("p2_m_srp_drop", 32'(rrMSrp), 32'd0);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p2_c_srr_once", 32'(rrCSrr), 32'd0);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0);
      checkOutput("p2_ld_m_ldp", 32'(rrMLdp), 32'd1);
      checkOutput("p2_ld_m_srp", 32'(rrMSrp), 32'd0);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p2_mismatch_c_ldr", 32'(rrCLdr), 32'd0);
      checkOutput("p2_mismatch_c_srr", 32'(rrCSrr), 32'd0);
      checkOutput("p2_mismatch_m_ldp", 32'(rrMLdp), 32'd1);
      applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h77);
      checkOutput("p2_ld_hold", 32'(rrMLdp), 32'd1);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p2_c_ldr", 32'(rrCLdr), 32'b0001);
      checkOutput("p2_c_ldData", rrCLdData, 32'h77);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p2_c_ldr_after", 32'(rrCLdr), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h99);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("idle_spur_c_ldr", 32'(rrCLdr), 32'd0);
      checkOutput("idle_spur_c_srr", 32'(rrCSrr), 32'd0);
      checkOutput("idle_spur_ldData", rrCLdData, 32'h77);
      checkOutput("idle_spur_m_ldp", 32'(rrMLdp), 32'd0);

      // Reset while channel 2's load is in flight.
      applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p3_m_ldp", 32'(rrMLdp), 32'd1);
      checkOutput("p3_m_addr", rrMAddr, 32'h300);
      #2 reset = 1'b1;
      #1 checkOutput("p3_async_m_ldp", 32'(rrMLdp), 32'd0);
      checkOutput("p3_async_m_addr", rrMAddr, 32'd0);
      for (int cyc = 0; cyc < 2; cyc++) begin
         applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0);
         checkOutput("p3_rst_c_ldr", 32'(rrCLdr), 32'd0);
      end
      applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, 32'h0);
      reset = 1'b0;
      applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0, 32'h11);
      checkOutput("p3_ptr0_m_addr", rrMAddr, 32'h200);
      applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p3_ch0_c_ldr", 32'(rrCLdr), 32'b0001);
      checkOutput("p3_ch0_ldData", rrCLdData, 32'h11);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0);
      applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0, 32'h22);
      checkOutput("p3_ch1_m_ldp", 32'(rrMLdp), 32'd1);
      checkOutput("p3_ch1_m_addr", rrMAddr, 32'h100);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("p3_ch1_c_ldr", 32'(rrCLdr), 32'b0010);
      checkOutput("p3_ch1_ldData", rrCLdData, 32'h22);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

      // All four channels load continuously against the auto memory.
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset   = 1'b0;
      autoMem = 1'b1;
      rrCount = 0;
      fpCount = 0;
      budget  = 0;
      while (rrCount < 6 && budget < 60) begin
         applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0);
         budget++;
         if (rrCLdr != '0) begin
            checkOutput("rr_grant", 32'(rrCLdr), 32'd1 << grantOrder[rrCount]);
            checkOutput("rr_ldData", rrCLdData, chAddr[grantOrder[rrCount]] ^ DATA_KEY);
            rrCount++;
         end
         if (fpCLdr != '0 || fpCSrr != '0) begin
            checkOutput("fp_grant", 32'(fpCLdr), 32'b0001);
            checkOutput("fp_ldData", fpCLdData, chAddr[0] ^ DATA_KEY);
            fpCount++;
         end
      end
      checkOutput("rr_count", rrCount, 32'd6);
      checkOutput("fp_count", fpCount, 32'd6);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
